relu_maxpool: RTL

Post-convolution stage: takes the eight signed 69-bit channel results that the conv layer emits for each 24x24 output position and applies 2x2/stride-2 max pooling followed by ReLU. It produces eight 12x12 pooled feature maps, one pooled position per `pool_valid` pulse, for the next (dense/classifier) stage. Input arrives in raster order, one position per `in_valid` cycle, with arbitrary gaps between positions.

---
 rtl/relu_maxpool.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/relu_maxpool.sv
// 2x2/stride-2 max pooling followed by ReLU over eight signed conv channels.
// One pooled result per window, registered the cycle after the window's last sample.

module relu_maxpool_lane #(
  parameter int DATA_W = 69,
  parameter int LB_N   = 12,
  parameter int LBW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     vld_i,
  input  logic                     col_odd_i,
  input  logic                     row_odd_i,
  input  logic [LBW-1:0]           lb_idx_i,
  input  logic signed [DATA_W-1:0] smp_i,
  output logic signed [DATA_W-1:0] res_o
);
  logic signed [DATA_W-1:0] h_q;
  logic signed [DATA_W-1:0] lb_q [LB_N];
  logic signed [DATA_W-1:0] res_q, lb_rd, m_row, m;

  always_comb begin
    lb_rd = lb_q[lb_idx_i];
    m_row = (smp_i > h_q) ? smp_i : h_q;
    m     = (lb_rd > m_row) ? lb_rd : m_row;
  end

  // Hold/line buffers are always written before being read within a frame.
  always_ff @(posedge clk) begin
    if (vld_i && !col_odd_i) h_q <= smp_i;
    if (vld_i && col_odd_i && !row_odd_i) lb_q[lb_idx_i] <= m_row;
  end

  always_ff @(posedge clk) begin
    if (rst) res_q <= '0;
    else if (vld_i && col_odd_i && row_odd_i) res_q <= m[DATA_W-1] ? '0 : m;
  end

  assign res_o = res_q;
endmodule

module relu_maxpool #(
  parameter int IN_W   = 24,
  parameter int IN_H   = 24,
  parameter int DATA_W = 69
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_sof,
  input  logic signed [DATA_W-1:0] conv_result_1,
  input  logic signed [DATA_W-1:0] conv_result_2,
  input  logic signed [DATA_W-1:0] conv_result_3,
  input  logic signed [DATA_W-1:0] conv_result_4,
  input  logic signed [DATA_W-1:0] conv_result_5,
  input  logic signed [DATA_W-1:0] conv_result_6,
  input  logic signed [DATA_W-1:0] conv_result_7,
  input  logic signed [DATA_W-1:0] conv_result_8,
  output logic                     pool_valid,
  output logic signed [DATA_W-1:0] pool_result_1,
  output logic signed [DATA_W-1:0] pool_result_2,
  output logic signed [DATA_W-1:0] pool_result_3,
  output logic signed [DATA_W-1:0] pool_result_4,
  output logic signed [DATA_W-1:0] pool_result_5,
  output logic signed [DATA_W-1:0] pool_result_6,
  output logic signed [DATA_W-1:0] pool_result_7,
  output logic signed [DATA_W-1:0] pool_result_8,
  output logic [7:0]               pool_index,
  output logic                     frame_done
);
  localparam int NUM_LANES = 8;
  localparam int CW  = $clog2(IN_W);
  localparam int RW  = $clog2(IN_H);
  localparam int LBW = CW - 1;

  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          pool_valid_q, frame_done_q, fire;
  logic [7:0]    pool_index_q, idx_d;
  logic [NUM_LANES-1:0][DATA_W-1:0] smp, res;

  // A start-of-frame sample overrides whatever position the counters hold.
  always_comb begin
    col_eff = in_sof ? '0 : col_q;
    row_eff = in_sof ? '0 : row_q;
    col_d   = col_q;
    row_d   = row_q;
    if (in_valid) begin
      if (col_eff == CW'(IN_W - 1)) begin
        col_d = '0;
        row_d = (row_eff == RW'(IN_H - 1)) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
    fire  = in_valid & col_eff[0] & row_eff[0];
    idx_d = 8'(row_eff[RW-1:1]) * 8'(IN_W / 2) + 8'(col_eff[CW-1:1]);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= '0;
      row_q        <= '0;
      pool_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
      pool_index_q <= '0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      pool_valid_q <= fire;
      frame_done_q <= fire && (row_eff == RW'(IN_H - 1)) && (col_eff == CW'(IN_W - 1));
      if (fire) pool_index_q <= idx_d;
    end
  end

  assign smp = {conv_result_8, conv_result_7, conv_result_6, conv_result_5,
                conv_result_4, conv_result_3, conv_result_2, conv_result_1};

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    relu_maxpool_lane #(.DATA_W(DATA_W), .LB_N(IN_W / 2), .LBW(LBW)) u_lane (
      .clk      (clk),
      .rst      (rst),
      .vld_i    (in_valid),
      .col_odd_i(col_eff[0]),
      .row_odd_i(row_eff[0]),
      .lb_idx_i (col_eff[CW-1:1]),
      .smp_i    (smp[g]),
      .res_o    (res[g])
    );
  end

  assign pool_valid    = pool_valid_q;
  assign frame_done    = frame_done_q;
  assign pool_index    = pool_index_q;
  assign pool_result_1 = res[0];
  assign pool_result_2 = res[1];
  assign pool_result_3 = res[2];
  assign pool_result_4 = res[3];
  assign pool_result_5 = res[4];
  assign pool_result_6 = res[5];
  assign pool_result_7 = res[6];
  assign pool_result_8 = res[7];
endmodule
